// File: rtl/segment_weight_estimator.sv
// Histogram monitor for the weighted random segment chooser: counts each segment
// over a window of sum(weights)*rounds samples and checks every count against its weight.
module segment_weight_estimator #(
   parameter int WIDTH   = 12,
   parameter int ROUND_W = 8,
   parameter int CNT_W   = WIDTH + 3 + ROUND_W
) (
   input  logic               in_clock,
   input  logic               in_reset,
   input  logic               in_start,
   input  logic [WIDTH:0]     in_weight0,
   input  logic [WIDTH:0]     in_weight1,
   input  logic [WIDTH:0]     in_weight2,
   input  logic [WIDTH:0]     in_weight3,
   input  logic [ROUND_W-1:0] in_rounds,
   input  logic [WIDTH:0]     in_tolerance,
   input  logic               in_valid,
   input  logic [1:0]         in_segment_number,
   output logic [CNT_W-1:0]   out_count0,
   output logic [CNT_W-1:0]   out_count1,
   output logic [CNT_W-1:0]   out_count2,
   output logic [CNT_W-1:0]   out_count3,
   output logic               out_busy,
   output logic               out_done,
   output logic               out_pass
);

   typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

   state_t               state;
   state_t               state_nxt;

   logic [WIDTH:0]       w_in        [4];
   logic [WIDTH+2:0]     sum_w;
   logic [CNT_W-1:0]     total_w;
   logic [CNT_W-1:0]     expected_w  [4];

   logic [CNT_W-1:0]     total_p0;
   logic [CNT_W-1:0]     expected_p0 [4];
   logic [WIDTH:0]       tol_p0;
   logic [CNT_W-1:0]     sample_cnt;
   logic [CNT_W-1:0]     cnt         [4];
   logic                 pass_r;

   logic                 start_ok;
   logic                 accept;
   logic                 last_sample;
   logic                 check_pass;

   // Absolute difference carried one bit wider than the counts so it never wraps.
   function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic signed [CNT_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      abs_diff = (d < 0) ? $unsigned(-d) : $unsigned(d);
   endfunction

   always_comb begin
      w_in[0] = in_weight0;
      w_in[1] = in_weight1;
      w_in[2] = in_weight2;
      w_in[3] = in_weight3;
      sum_w   = (WIDTH+3)'(w_in[0]) + (WIDTH+3)'(w_in[1])
              + (WIDTH+3)'(w_in[2]) + (WIDTH+3)'(w_in[3]);
      total_w = CNT_W'(sum_w) * CNT_W'(in_rounds);
      for (int i = 0; i < 4; i++) begin
         expected_w[i] = CNT_W'(w_in[i]) * CNT_W'(in_rounds);
      end
   end

   assign start_ok    = in_start && ((state == IDLE) || (state == DONE));
   assign accept      = (state == COLLECT) && in_valid;
   assign last_sample = accept && (sample_cnt == (total_p0 - CNT_W'(1)));

   always_comb begin
      check_pass = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (abs_diff(cnt[i], expected_p0[i]) > (CNT_W+1)'(tol_p0)) begin
            check_pass = 1'b0;
         end
      end
   end

   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start_ok) begin
               state_nxt = (total_w == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (last_sample) begin
               state_nxt = CHECK;
            end
         end
         CHECK:   state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_busy = 1'b0;
      out_done = 1'b0;
      case (state)
         COLLECT, CHECK: out_busy = 1'b1;
         DONE:           out_done = 1'b1;
         default:        ;
      endcase
   end

   // Start latches the window; a zero-length window passes trivially.
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         total_p0   <= '0;
         tol_p0     <= '0;
         sample_cnt <= '0;
         pass_r     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            expected_p0[i] <= '0;
            cnt[i]         <= '0;
         end
      end else if (start_ok) begin
         total_p0   <= total_w;
         tol_p0     <= in_tolerance;
         sample_cnt <= '0;
         pass_r     <= (total_w == '0);
         for (int i = 0; i < 4; i++) begin
            expected_p0[i] <= expected_w[i];
            cnt[i]         <= '0;
         end
      end else if (accept) begin
         sample_cnt             <= sample_cnt + CNT_W'(1);
         cnt[in_segment_number] <= cnt[in_segment_number] + CNT_W'(1);
      end else if (state == CHECK) begin
         pass_r <= check_pass;
      end
   end

   assign out_count0 = cnt[0];
   assign out_count1 = cnt[1];
   assign out_count2 = cnt[2];
   assign out_count3 = cnt[3];
   assign out_pass   = pass_r;

endmodule

// File: tb/tb_segment_weight_estimator.sv
// Directed scoreboard bench for segment_weight_estimator.
module tb_segment_weight_estimator;

   localparam int WIDTH   = 12;
   localparam int ROUND_W = 8;
   localparam int CNT_W   = WIDTH + 3 + ROUND_W;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               valid = 1'b0;
   logic [1:0]         seg = 2'd0;
   logic [WIDTH:0]     w0 = '0, w1 = '0, w2 = '0, w3 = '0, tol = '0;
   logic [ROUND_W-1:0] rounds = '0;
   logic [CNT_W-1:0]   c0, c1, c2, c3;
   logic               busy, done, pass;

   segment_weight_estimator #(.WIDTH(WIDTH), .ROUND_W(ROUND_W), .CNT_W(CNT_W)) dut (
      .in_clock(clk), .in_reset(rst_n), .in_start(start),
      .in_weight0(w0), .in_weight1(w1), .in_weight2(w2), .in_weight3(w3),
      .in_rounds(rounds), .in_tolerance(tol),
      .in_valid(valid), .in_segment_number(seg),
      .out_count0(c0), .out_count1(c1), .out_count2(c2), .out_count3(c3),
      .out_busy(busy), .out_done(done), .out_pass(pass)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c0, c1, c2, c3;
      bit pass;
   } exp_t;

   exp_t sb[$];
   int   stim[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int a, input int b, input int c, input int d,
                          input int r, input int t);
      w0 = a[WIDTH:0]; w1 = b[WIDTH:0]; w2 = c[WIDTH:0]; w3 = d[WIDTH:0];
      rounds = r[ROUND_W-1:0]; tol = t[WIDTH:0];
   endtask

   task automatic build_exact();
      stim.delete();
      repeat (10) begin
         stim.push_back(0); stim.push_back(0);
         stim.push_back(1); stim.push_back(1); stim.push_back(1); stim.push_back(1);
         stim.push_back(2); stim.push_back(2);
      end
   endtask

   task automatic build_list(input int n, input int v);
      repeat (n) stim.push_back(v);
   endtask

   // One full measurement: model, start, stream, verdict, scoreboard compare.
   task automatic run_window(input string tag, input bit gap, input int start_at);
      exp_t e;
      exp_t got;
      int   m[4];
      int   wv[4];
      int   tot, d, driven, busy_cyc;
      logic [ROUND_W-1:0] r_save;
      m  = '{0, 0, 0, 0};
      wv = '{int'(w0), int'(w1), int'(w2), int'(w3)};
      foreach (stim[k]) m[stim[k]]++;
      tot    = (wv[0] + wv[1] + wv[2] + wv[3]) * int'(rounds);
      e.pass = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = m[i] - wv[i] * int'(rounds);
         if (d < 0) d = -d;
         if (d > int'(tol)) e.pass = 1'b0;
      end
      e.c0 = m[0]; e.c1 = m[1]; e.c2 = m[2]; e.c3 = m[3];
      sb.push_back(e);

      start = 1'b1;
      cycle();
      start = 1'b0;
      chk({tag, " busy_after_start"}, busy, tot > 0);
      chk({tag, " done_after_start"}, done, tot == 0);
      chk({tag, " counts_cleared"}, c0 | c1 | c2 | c3, 0);
      busy_cyc = busy;
      driven   = 0;
      if (tot > 0) begin
         foreach (stim[k]) begin
            if (gap && k > 0) begin
               valid = 1'b0;
               cycle();
               busy_cyc += busy;
               driven++;
            end
            valid = 1'b1;
            seg   = stim[k][1:0];
            if (k == start_at) begin
               start  = 1'b1;
               r_save = rounds;
               rounds = 8'd1;
            end
            cycle();
            busy_cyc += busy;
            driven++;
            if (k == start_at) begin
               start  = 1'b0;
               rounds = r_save;
               chk({tag, " start_ignored_sum"}, c0 + c1 + c2 + c3, k + 1);
               chk({tag, " start_ignored_busy"}, busy, 1);
            end
         end
         valid = 1'b0;
         chk({tag, " check_busy"}, busy, 1);
         chk({tag, " check_not_done"}, done, 0);
         cycle();
         chk({tag, " verdict_done"}, done, 1);
         chk({tag, " verdict_not_busy"}, busy, 0);
         chk({tag, " busy_cycles"}, busy_cyc, driven + 1);
      end
      // A valid sample while DONE must not move the counts.
      valid = 1'b1;
      seg   = 2'd0;
      cycle();
      valid = 1'b0;

      got = sb.pop_front();
      chk({tag, " count0"}, c0, got.c0);
      chk({tag, " count1"}, c1, got.c1);
      chk({tag, " count2"}, c2, got.c2);
      chk({tag, " count3"}, c3, got.c3);
      chk({tag, " pass"}, pass, got.pass);
      chk({tag, " done_held"}, done, 1);
   endtask

   initial begin
      // Reset state
      repeat (2) cycle();
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset pass", pass, 0);
      chk("reset counts", c0 | c1 | c2 | c3, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      set_cfg(2, 4, 2, 0, 10, 0);
      build_exact();
      run_window("exact", 1'b0, -1);

      set_cfg(2, 4, 2, 0, 10, 5);
      stim.delete();
      build_list(80, 0);
      run_window("skewed", 1'b0, -1);

      set_cfg(1, 1, 1, 1, 4, 1);
      stim.delete();
      repeat (3) begin
         stim.push_back(0); stim.push_back(1); stim.push_back(2); stim.push_back(3);
      end
      stim.push_back(1); stim.push_back(1); stim.push_back(2); stim.push_back(3);
      run_window("gaps", 1'b1, -1);

      set_cfg(1, 1, 1, 0, 4, 1);
      stim.delete();
      build_list(4, 3); build_list(3, 0); build_list(3, 1); build_list(2, 2);
      run_window("zero_weight_hit", 1'b1, -1);

      set_cfg(1, 0, 0, 0, 2, 2);
      stim.delete();
      build_list(2, 3);
      run_window("tol_ge_total", 1'b0, -1);

      // Asynchronous reset in the middle of a window
      set_cfg(2, 4, 2, 0, 10, 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      valid = 1'b1;
      for (int k = 0; k < 30; k++) begin
         seg = k[1:0] == 2'd3 ? 2'd2 : k[1:0];
         cycle();
      end
      chk("pre_reset count_sum", c0 + c1 + c2 + c3, 30);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset busy", busy, 0);
      chk("async_reset done", done, 0);
      chk("async_reset pass", pass, 0);
      chk("async_reset counts", c0 | c1 | c2 | c3, 0);
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      build_exact();
      run_window("after_reset", 1'b0, -1);

      set_cfg(2, 4, 2, 0, 0, 0);
      stim.delete();
      run_window("degenerate", 1'b0, -1);

      set_cfg(2, 4, 2, 0, 10, 0);
      build_exact();
      run_window("start_mid_collect", 1'b0, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
